// File: rtl/sram_state_tracker_pkg.sv
// Shared defaults and enumerations for the per-SRAM page bookkeeping block.
package sram_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_PORTS  = 16;
    localparam int DEF_ECC_W  = 8;

    typedef logic [$clog2(DEF_PORTS)-1:0] port_idx_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOW   = 2'd1,
        MID   = 2'd2,
        HIGH  = 2'd3
    } bucket_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sram_state_tracker_free_page_fifo.sv
// Free-page list: circular FIFO with first-word-fall-through head and an occupancy count.
module free_page_fifo #(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] din,
    input  logic              pop,
    output logic [ADDR_W-1:0] dout,
    output logic [ADDR_W:0]   count
);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is 2**ADDR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/sram_state_tracker.sv
// Per-SRAM tracker: free list, free-space/full, per-port occupancy buckets, burst flags and ECC store.
module sram_state_tracker import sram_pkg::*; #(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int PORTS       = DEF_PORTS,
    parameter int ECC_W       = DEF_ECC_W,
    parameter int BATCH       = 8,
    parameter int THR_LO      = 512,
    parameter int THR_HI      = 1536,
    parameter int FULL_MARGIN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_ecc_en,
    input  logic [ADDR_W-1:0]        wr_ecc_addr,
    input  logic [ECC_W-1:0]         wr_ecc_code,
    input  logic [ADDR_W-1:0]        rd_ecc_addr,
    output logic [ECC_W-1:0]         rd_ecc_code,
    input  logic                     wr_op,
    input  logic [$clog2(PORTS)-1:0] wr_port,
    input  logic                     rd_op,
    input  logic [$clog2(PORTS)-1:0] rd_port,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [ADDR_W-1:0]        null_ptr,
    output logic                     init_done,
    output logic [ADDR_W:0]          free_space,
    output logic                     full,
    output logic                     writing,
    output logic                     reading,
    output logic [2*PORTS-1:0]       prefer,
    output logic                     err_ovf,
    output logic                     err_udf
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int PW    = $clog2(PORTS);
    localparam int CW    = ADDR_W + 1;
    localparam int BW    = (BATCH > 1) ? $clog2(BATCH) : 1;

    state_t            state;
    logic [ADDR_W-1:0] init_k;
    logic [CW-1:0]     cnt [PORTS];
    logic [BW-1:0]     wr_batch;
    logic [BW-1:0]     rd_batch;
    logic              wr_acc;
    logic              rd_acc;
    logic              fifo_push;
    logic [ADDR_W-1:0] fifo_din;
    logic [CW-1:0]     free_next;
    logic [ECC_W-1:0]  ecc_mem [DEPTH];

    function automatic bucket_t bucket(input logic [CW-1:0] c);
        if (c == '0)               return EMPTY;
        else if (c < CW'(THR_LO))  return LOW;
        else if (c < CW'(THR_HI))  return MID;
        else                       return HIGH;
    endfunction

    // Init pushes share the FIFO push port with released pages.
    always_comb begin
        wr_acc    = wr_op && (state == RUN) && (free_space != '0);
        rd_acc    = rd_op && (state == RUN) && (cnt[rd_port] != '0);
        fifo_push = (state == INIT) || rd_acc;
        fifo_din  = (state == INIT) ? init_k : rd_addr;
        free_next = free_space + CW'(fifo_push) - CW'(wr_acc);
    end

    free_page_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_free_list (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (wr_acc),
        .dout  (null_ptr),
        .count (free_space)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            init_k    <= '0;
            init_done <= 1'b0;
            full      <= 1'b1;
            writing   <= 1'b0;
            reading   <= 1'b0;
            wr_batch  <= '0;
            rd_batch  <= '0;
            err_ovf   <= 1'b0;
            err_udf   <= 1'b0;
        end else begin
            err_ovf <= wr_op && !wr_acc;
            err_udf <= rd_op && !rd_acc;
            full    <= (free_next <= CW'(FULL_MARGIN));
            if (state == INIT) begin
                init_k <= init_k + 1'b1;
                if (init_k == ADDR_W'(DEPTH-1)) begin
                    state     <= RUN;
                    init_done <= 1'b1;
                end
            end
            if (wr_acc) begin
                writing  <= 1'b1;
                wr_batch <= '0;
            end else if (writing) begin
                if (wr_batch == BW'(BATCH-1)) writing  <= 1'b0;
                else                          wr_batch <= wr_batch + 1'b1;
            end
            if (rd_acc) begin
                reading  <= 1'b1;
                rd_batch <= '0;
            end else if (reading) begin
                if (rd_batch == BW'(BATCH-1)) reading  <= 1'b0;
                else                          rd_batch <= rd_batch + 1'b1;
            end
        end
    end

    // prefer samples the count registers, so it trails them by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned j = 0; j < PORTS; j++) cnt[j] <= '0;
            prefer <= '0;
        end else begin
            for (int unsigned j = 0; j < PORTS; j++) begin
                cnt[j] <= cnt[j] + CW'(wr_acc && (wr_port == PW'(j)))
                                 - CW'(rd_acc && (rd_port == PW'(j)));
                prefer[2*j +: 2] <= bucket(cnt[j]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ecc_en) ecc_mem[wr_ecc_addr] <= wr_ecc_code;
    end

    always_ff @(posedge clk) begin
        if (rst) rd_ecc_code <= '0;
        else     rd_ecc_code <= ecc_mem[rd_ecc_addr];
    end

endmodule

// File: tb/tb_sram_state_tracker.sv
// Scoreboard bench for sram_state_tracker: queue-based reference model, per-cycle expectations, decoupled monitor.
module tb_sram_state_tracker;
    import sram_pkg::*;

    localparam int ADDR_W      = 11;
    localparam int PORTS       = 16;
    localparam int ECC_W       = 8;
    localparam int BATCH       = 8;
    localparam int THR_LO      = 512;
    localparam int THR_HI      = 1536;
    localparam int FULL_MARGIN = 1;
    localparam int DEPTH       = 2**ADDR_W;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wr_ecc_en;
    logic [ADDR_W-1:0]    wr_ecc_addr;
    logic [ECC_W-1:0]     wr_ecc_code;
    logic [ADDR_W-1:0]    rd_ecc_addr;
    logic [ECC_W-1:0]     rd_ecc_code;
    logic                 wr_op;
    port_idx_t            wr_port;
    logic                 rd_op;
    port_idx_t            rd_port;
    logic [ADDR_W-1:0]    rd_addr;
    logic [ADDR_W-1:0]    null_ptr;
    logic                 init_done;
    logic [ADDR_W:0]      free_space;
    logic                 full;
    logic                 writing;
    logic                 reading;
    logic [2*PORTS-1:0]   prefer;
    logic                 err_ovf;
    logic                 err_udf;

    always #5 clk = ~clk;

    sram_state_tracker #(
        .ADDR_W      (ADDR_W),
        .PORTS       (PORTS),
        .ECC_W       (ECC_W),
        .BATCH       (BATCH),
        .THR_LO      (THR_LO),
        .THR_HI      (THR_HI),
        .FULL_MARGIN (FULL_MARGIN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_ecc_en   (wr_ecc_en),
        .wr_ecc_addr (wr_ecc_addr),
        .wr_ecc_code (wr_ecc_code),
        .rd_ecc_addr (rd_ecc_addr),
        .rd_ecc_code (rd_ecc_code),
        .wr_op       (wr_op),
        .wr_port     (wr_port),
        .rd_op       (rd_op),
        .rd_port     (rd_port),
        .rd_addr     (rd_addr),
        .null_ptr    (null_ptr),
        .init_done   (init_done),
        .free_space  (free_space),
        .full        (full),
        .writing     (writing),
        .reading     (reading),
        .prefer      (prefer),
        .err_ovf     (err_ovf),
        .err_udf     (err_udf)
    );

    typedef struct {
        logic [ADDR_W:0]    free_space;
        logic [ADDR_W-1:0]  null_ptr;
        bit                 chk_null;
        logic               init_done;
        logic               full;
        logic               writing;
        logic               reading;
        logic               err_ovf;
        logic               err_udf;
        logic [2*PORTS-1:0] prefer;
        logic [ECC_W-1:0]   ecc;
        bit                 chk_ecc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int fl[$];
    int cnt[PORTS];
    int owned[PORTS][$];
    bit run;
    int init_k;
    int n = 0;
    int last_wr = -100;
    int last_rd = -100;
    int ecc_val[DEPTH];
    bit ecc_known[DEPTH];

    function automatic int bucket_of(int c);
        if (c == 0)           return 0;
        else if (c < THR_LO)  return 1;
        else if (c < THR_HI)  return 2;
        else                  return 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply current inputs to the model, queue the expected post-edge outputs, advance one cycle.
    task automatic tick();
        exp_t e;
        bit   wacc;
        bit   racc;
        int   pg;
        e = '{default: 0};
        n++;
        for (int j = 0; j < PORTS; j++) e.prefer[2*j +: 2] = 2'(bucket_of(cnt[j]));
        if (rst) begin
            fl.delete();
            for (int j = 0; j < PORTS; j++) begin
                cnt[j] = 0;
                owned[j].delete();
            end
            run     = 0;
            init_k  = 0;
            last_wr = -100;
            last_rd = -100;
            e.prefer  = '0;
            e.ecc     = '0;
            e.chk_ecc = 1;
        end else begin
            if (ecc_known[rd_ecc_addr]) begin
                e.chk_ecc = 1;
                e.ecc     = ECC_W'(ecc_val[rd_ecc_addr]);
            end
            if (!run) begin
                fl.push_back(init_k);
                init_k++;
                if (init_k == DEPTH) run = 1;
                e.err_ovf = wr_op;
                e.err_udf = rd_op;
            end else begin
                wacc = wr_op && (fl.size() != 0);
                racc = rd_op && (cnt[rd_port] != 0);
                if (wacc) begin
                    pg = fl.pop_front();
                    cnt[wr_port]++;
                    owned[wr_port].push_back(pg);
                    last_wr = n;
                end
                if (racc) begin
                    fl.push_back(int'(rd_addr));
                    cnt[rd_port]--;
                    for (int k = 0; k < owned[rd_port].size(); k++) begin
                        if (owned[rd_port][k] == int'(rd_addr)) begin
                            owned[rd_port].delete(k);
                            break;
                        end
                    end
                    last_rd = n;
                end
                e.err_ovf = wr_op && !wacc;
                e.err_udf = rd_op && !racc;
            end
            e.init_done = run;
        end
        // Read-first: the store is updated after the read above was sampled.
        if (wr_ecc_en) begin
            ecc_val[wr_ecc_addr]   = int'(wr_ecc_code);
            ecc_known[wr_ecc_addr] = 1;
        end
        e.free_space = (ADDR_W+1)'(fl.size());
        e.chk_null   = (fl.size() != 0);
        if (e.chk_null) e.null_ptr = ADDR_W'(fl[0]);
        e.full    = (fl.size() <= FULL_MARGIN);
        e.writing = (n - last_wr) < BATCH;
        e.reading = (n - last_rd) < BATCH;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("free_space", 32'(free_space), 32'(e.free_space));
                chk("init_done",  32'(init_done),  32'(e.init_done));
                chk("full",       32'(full),       32'(e.full));
                chk("writing",    32'(writing),    32'(e.writing));
                chk("reading",    32'(reading),    32'(e.reading));
                chk("err_ovf",    32'(err_ovf),    32'(e.err_ovf));
                chk("err_udf",    32'(err_udf),    32'(e.err_udf));
                chk("prefer",     32'(prefer),     32'(e.prefer));
                if (e.chk_null) chk("null_ptr", 32'(null_ptr), 32'(e.null_ptr));
                if (e.chk_ecc)  chk("rd_ecc_code", 32'(rd_ecc_code), 32'(e.ecc));
            end
        end
    end

    task automatic idle_inputs();
        wr_op     = 0;
        rd_op     = 0;
        wr_ecc_en = 0;
    endtask

    task automatic run_init();
        rst = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr_op   = (i == 10);
            rd_op   = (i == 20);
            rd_port = 0;
            tick();
        end
        idle_inputs();
    endtask

    initial begin : driver
        int p;
        #1;
        rst = 1; idle_inputs();
        wr_port = 0; rd_port = 0; rd_addr = 0;
        wr_ecc_addr = 0; wr_ecc_code = 0; rd_ecc_addr = 0;
        repeat (3) tick();
        run_init();

        // Three allocations on port 5, then let the write burst expire
        for (int i = 0; i < 3; i++) begin
            wr_op = 1; wr_port = 5; tick();
        end
        wr_op = 0;
        repeat (10) tick();

        // Release 1 then 0, then drain the list through the wrap point
        rd_op = 1; rd_port = 5; rd_addr = 1; tick();
        rd_addr = 0; tick();
        rd_op = 0; tick();
        for (int i = 0; i < 3 * DEPTH && fl.size() != 0; i++) begin
            wr_op = 1; wr_port = port_idx_t'($urandom_range(0, PORTS-1)); tick();
        end
        wr_op = 1; tick();
        p = 0;
        for (int j = 0; j < PORTS; j++) if (owned[j].size() != 0) p = j;
        wr_op = 1; rd_op = 1; rd_port = port_idx_t'(p); rd_addr = ADDR_W'(owned[p][0]); tick();
        idle_inputs(); repeat (3) tick();

        // ECC read-first collision at address 7
        wr_ecc_en = 1; wr_ecc_addr = 7; wr_ecc_code = 8'h3C; rd_ecc_addr = 7; tick();
        wr_ecc_code = 8'hA5; tick();
        wr_ecc_en = 0; tick();
        tick();

        // Reset mid-run, re-init, build port 3 up to 600 pages
        rst = 1; repeat (2) tick();
        run_init();
        for (int i = 0; i < 600; i++) begin
            wr_op = 1; wr_port = 3; tick();
        end
        for (int i = 0; i < 4; i++) begin
            wr_op = 1; wr_port = 3; rd_op = 1; rd_port = 3; rd_addr = ADDR_W'(owned[3][0]); tick();
        end
        idle_inputs(); repeat (3) tick();
        rd_op = 1; rd_port = 9; rd_addr = 5; tick();
        idle_inputs(); tick();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            wr_op   = ($urandom_range(0, 1) == 1);
            wr_port = port_idx_t'($urandom_range(0, PORTS-1));
            rd_op   = ($urandom_range(0, 1) == 1);
            rd_port = port_idx_t'($urandom_range(0, PORTS-1));
            if (owned[rd_port].size() != 0)
                rd_addr = ADDR_W'(owned[rd_port][$urandom_range(0, owned[rd_port].size()-1)]);
            else
                rd_addr = ADDR_W'($urandom);
            wr_ecc_en   = ($urandom_range(0, 3) == 0);
            wr_ecc_addr = ADDR_W'($urandom_range(0, 15));
            wr_ecc_code = ECC_W'($urandom);
            rd_ecc_addr = ADDR_W'($urandom_range(0, 15));
            tick();
        end
        idle_inputs(); repeat (BATCH + 2) tick();

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
